// File: rtl/rock_motion_gen.sv
// Cradle rocking setpoint generator: triangular pos trajectory plus PWM drive.
// Amplitude/frequency are taken only at rest; a fault ramps the cradle back to rest.
module rock_motion_gen #(
  parameter int AMP_STEP = 16,
  parameter int BASE_DIV = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        A,
  input  logic [2:0]        F,
  input  logic              err,
  output logic signed [7:0] pos,
  output logic              dir,
  output logic              pwm,
  output logic              active,
  output logic              cycle_done,
  output logic              fault
);
  localparam int DATA_W = 8;
  localparam int DIV_W  = $clog2(BASE_DIV * 8 + 1);

  typedef enum logic [2:0] {S_IDLE, S_UP, S_DOWN, S_RETURN, S_FRAMP, S_FAULT} state_t;

  state_t                   state_q, state_d;
  logic signed [DATA_W-1:0] pos_q, pos_d, amp_q, amp_d, pos_step;
  logic [DIV_W-1:0]         div_q, div_d, scnt_q, scnt_d;
  logic [7:0]               pcnt_q, pcnt_d;
  logic                     dir_q, dir_d, pwm_q, pwm_d;
  logic                     active_q, active_d, done_q, done_d, fault_q, fault_d;
  logic                     run_req, step;

  // pos+128 as an unsigned byte: flipping the sign bit is the offset-binary form
  function automatic logic [7:0] pwm_thresh(input logic signed [DATA_W-1:0] p);
    return {~p[DATA_W-1], p[DATA_W-2:0]};
  endfunction

  function automatic logic signed [DATA_W-1:0] amp_of(input logic [2:0] a);
    return DATA_W'(int'(a) * AMP_STEP);
  endfunction

  function automatic logic [DIV_W-1:0] div_of(input logic [2:0] f);
    return DIV_W'(BASE_DIV * (8 - int'(f)));
  endfunction

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    amp_d    = amp_q;
    div_d    = div_q;
    scnt_d   = scnt_q;
    done_d   = 1'b0;
    run_req  = (A != 3'd0) && (F != 3'd0);
    step     = (scnt_q == div_q - DIV_W'(1));
    pos_step = (state_q == S_DOWN) ? pos_q - 8'sd1 : pos_q + 8'sd1;

    case (state_q)
      S_IDLE: begin
        if (err) begin
          state_d = S_FAULT;
        end else if (run_req) begin
          amp_d   = amp_of(A);
          div_d   = div_of(F);
          scnt_d  = '0;
          state_d = S_UP;
        end
      end
      S_UP, S_DOWN, S_RETURN: begin
        // a fault wins over a step landing on the same clock
        if (err) begin
          state_d = S_FRAMP;
        end else if (!step) begin
          scnt_d = scnt_q + DIV_W'(1);
        end else begin
          scnt_d = '0;
          pos_d  = pos_step;
          if (state_q == S_UP && pos_step == amp_q) begin
            state_d = S_DOWN;
          end else if (state_q == S_DOWN && pos_step == -amp_q) begin
            state_d = S_RETURN;
          end else if (state_q == S_RETURN && pos_step == '0) begin
            done_d = 1'b1;
            if (run_req) begin
              amp_d   = amp_of(A);
              div_d   = div_of(F);
              state_d = S_UP;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      S_FRAMP: begin
        if (pos_q > 0) begin
          pos_d = pos_q - 8'sd1;
        end else if (pos_q < 0) begin
          pos_d = pos_q + 8'sd1;
        end
        if (pos_d == '0) state_d = S_FAULT;
      end
      S_FAULT: begin
        if (!err) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    dir_d    = (state_d == S_UP) || (state_d == S_RETURN) ||
               ((state_d == S_FRAMP) && (pos_d < 0));
    active_d = (state_d == S_UP) || (state_d == S_DOWN) || (state_d == S_RETURN);
    fault_d  = (state_d == S_FRAMP) || (state_d == S_FAULT);
    pcnt_d   = pcnt_q + 8'd1;
    pwm_d    = pcnt_q < pwm_thresh(pos_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pos_q    <= '0;
      amp_q    <= '0;
      div_q    <= '0;
      scnt_q   <= '0;
      pcnt_q   <= '0;
      dir_q    <= 1'b0;
      pwm_q    <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      amp_q    <= amp_d;
      div_q    <= div_d;
      scnt_q   <= scnt_d;
      pcnt_q   <= pcnt_d;
      dir_q    <= dir_d;
      pwm_q    <= pwm_d;
      active_q <= active_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
    end
  end

  assign pos        = pos_q;
  assign dir        = dir_q;
  assign pwm        = pwm_q;
  assign active     = active_q;
  assign cycle_done = done_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_rock_motion_gen.sv
// Bench for rock_motion_gen: directed vector table, corner sequences and a
// randomized run, all compared against a triangle-wave reference model.
module tb_rock_motion_gen;
  localparam int AS = 2;
  localparam int BD = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_RAMP = 2, M_FAULT = 3;

  logic              clk = 1'b0;
  logic              reset, err;
  logic [2:0]        A, F;
  logic signed [7:0] pos;
  logic              dir, pwm, active, cycle_done, fault;

  int n_chk = 0;
  int n_pass = 0;

  rock_motion_gen #(.AMP_STEP(AS), .BASE_DIV(BD)) dut (
    .clk(clk), .reset(reset), .A(A), .F(F), .err(err),
    .pos(pos), .dir(dir), .pwm(pwm), .active(active),
    .cycle_done(cycle_done), .fault(fault)
  );

  always #5 clk = ~clk;

  // reference model: the running cradle is a triangle wave of the step index
  int m_mode, m_j, m_a, m_d, m_pos, m_pcnt;
  bit m_pwm, m_done;

  function automatic int tri_pos(input int n, input int a);
    if (n <= a) return n;
    else if (n <= 3 * a) return 2 * a - n;
    else return n - 4 * a;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_j = 0; m_a = 0; m_d = 1; m_pos = 0;
    m_pcnt = 0; m_pwm = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_step();
    m_pwm  = (m_pcnt < m_pos + 128);
    m_pcnt = (m_pcnt + 1) % 256;
    m_done = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (err) m_mode = M_FAULT;
        else if (A != 0 && F != 0) begin
          m_a = int'(A) * AS; m_d = BD * (8 - int'(F)); m_j = 0; m_mode = M_RUN;
        end
      end
      M_RUN: begin
        if (err) m_mode = M_RAMP;
        else begin
          m_j++;
          m_pos = tri_pos(m_j / m_d, m_a);
          if (m_j == 4 * m_a * m_d) begin
            m_done = 1'b1;
            if (A != 0 && F != 0) begin
              m_a = int'(A) * AS; m_d = BD * (8 - int'(F)); m_j = 0;
            end else m_mode = M_IDLE;
          end
        end
      end
      M_RAMP: begin
        if (m_pos > 0) m_pos--;
        else if (m_pos < 0) m_pos++;
        if (m_pos == 0) m_mode = M_FAULT;
      end
      default: if (!err) m_mode = M_IDLE;
    endcase
  endtask

  function automatic logic [4:0] m_flags();
    logic d;
    int n;
    d = 1'b0;
    if (m_mode == M_RUN) begin
      n = m_j / m_d;
      d = (n < m_a) || (n >= 3 * m_a);
    end else if (m_mode == M_RAMP) d = (m_pos < 0);
    return {d, (m_mode == M_RUN), m_done, (m_mode == M_RAMP) || (m_mode == M_FAULT), m_pwm};
  endfunction

  task automatic check(input string name, input logic signed [31:0] got,
                       input logic signed [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("model_pos", 32'(pos), m_pos);
    check("model_flags", 32'({dir, active, cycle_done, fault, pwm}), 32'(m_flags()));
  endtask

  // flg = {dir, active, cycle_done, fault}
  typedef struct {
    logic [2:0] a;
    logic [2:0] f;
    logic       e;
    int         ncl;
    int         pos;
    logic [3:0] flg;
  } vec_t;

  vec_t vt[19];
  int   ramp_exp[6] = '{5, 4, 3, 2, 1, 0};
  int   hi, mn, mx;

  initial begin
    vt[0]  = '{3'd1, 3'd7, 1'b0, 1,  0, 4'b1100};
    vt[1]  = '{3'd1, 3'd7, 1'b0, 1,  0, 4'b1100};
    vt[2]  = '{3'd1, 3'd7, 1'b0, 1,  1, 4'b1100};
    vt[3]  = '{3'd1, 3'd7, 1'b0, 1,  1, 4'b1100};
    vt[4]  = '{3'd1, 3'd7, 1'b0, 1,  2, 4'b0100};
    vt[5]  = '{3'd1, 3'd7, 1'b0, 1,  2, 4'b0100};
    vt[6]  = '{3'd1, 3'd7, 1'b0, 1,  1, 4'b0100};
    vt[7]  = '{3'd1, 3'd7, 1'b0, 1,  1, 4'b0100};
    vt[8]  = '{3'd1, 3'd7, 1'b0, 1,  0, 4'b0100};
    vt[9]  = '{3'd1, 3'd7, 1'b0, 1,  0, 4'b0100};
    vt[10] = '{3'd1, 3'd7, 1'b0, 1, -1, 4'b0100};
    vt[11] = '{3'd1, 3'd7, 1'b0, 1, -1, 4'b0100};
    vt[12] = '{3'd1, 3'd7, 1'b0, 1, -2, 4'b1100};
    vt[13] = '{3'd1, 3'd7, 1'b0, 1, -2, 4'b1100};
    vt[14] = '{3'd1, 3'd7, 1'b0, 1, -1, 4'b1100};
    vt[15] = '{3'd1, 3'd7, 1'b0, 1, -1, 4'b1100};
    vt[16] = '{3'd1, 3'd7, 1'b0, 1,  0, 4'b1110};
    vt[17] = '{3'd1, 3'd7, 1'b0, 1,  0, 4'b1100};
    vt[18] = '{3'd1, 3'd7, 1'b0, 1,  1, 4'b1100};

    reset = 1'b1; A = 3'd0; F = 3'd0; err = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_pos", 32'(pos), 0);
    check("rst_flags", 32'({dir, pwm, active, cycle_done, fault}), 0);
    reset = 1'b0;

    // idle hold: 50% duty
    repeat (40) tick();
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      hi = hi + int'(pwm);
    end
    check("pwm_idle_duty", hi, 128);

    for (int i = 0; i < 19; i++) begin
      A = vt[i].a; F = vt[i].f; err = vt[i].e;
      repeat (vt[i].ncl) tick();
      check($sformatf("vec%0d_pos", i), 32'(pos), vt[i].pos);
      check($sformatf("vec%0d_flags", i), 32'({dir, active, cycle_done, fault}), 32'(vt[i].flg));
    end

    // amplitude change during DOWN only takes effect on the next cycle
    for (int i = 0; i < 100 && !(active && !dir); i++) tick();
    check("wait_down", 32'(active && !dir), 1);
    A = 3'd3;
    mn = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (int'(pos) < mn) mn = int'(pos);
      if (cycle_done) break;
    end
    check("old_cycle_done", 32'(cycle_done), 1);
    check("old_cycle_min", mn, -2);
    mn = 0; mx = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (int'(pos) < mn) mn = int'(pos);
      if (int'(pos) > mx) mx = int'(pos);
      if (cycle_done) break;
    end
    check("new_cycle_done", 32'(cycle_done), 1);
    check("new_cycle_max", mx, 6);
    check("new_cycle_min", mn, -6);

    // F dropped during UP: cycle completes, then idle
    for (int i = 0; i < 200 && !(active && dir && pos > 0); i++) tick();
    check("wait_up", 32'(active && dir && pos > 0), 1);
    F = 3'd0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (cycle_done) break;
    end
    check("f0_done", 32'(cycle_done), 1);
    check("f0_active", 32'(active), 0);
    check("f0_pos", 32'(pos), 0);
    repeat (10) tick();
    check("f0_stay_pos", 32'(pos), 0);
    check("f0_stay_active", 32'(active), 0);

    // err at pos=5 while rising
    A = 3'd3; F = 3'd7;
    for (int i = 0; i < 200 && !(pos == 5 && dir); i++) tick();
    check("wait_pos5", 32'(pos == 5 && dir), 1);
    err = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("ramp%0d_pos", k), 32'(pos), ramp_exp[k]);
      check($sformatf("ramp%0d_fault", k), 32'(fault), 1);
    end
    repeat (5) tick();
    check("fault_hold_pos", 32'(pos), 0);
    check("fault_hold", 32'({fault, active}), 2);
    err = 1'b0;
    tick();
    check("fault_clear", 32'({fault, active}), 0);
    tick();
    check("fault_restart", 32'(active), 1);

    // asynchronous reset mid-cycle
    for (int i = 0; i < 200 && pos != -3; i++) tick();
    check("wait_neg3", 32'(pos), -3);
    #2 reset = 1'b1;
    #1;
    check("async_pos", 32'(pos), 0);
    check("async_pwm", 32'(pwm), 0);
    check("async_flags", 32'({dir, active, cycle_done, fault}), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    check("post_reset_active", 32'(active), 0);
    tick();
    check("restart_active", 32'(active), 1);
    check("restart_dir", 32'(dir), 1);

    // randomized run against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) A = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) F = 3'($urandom_range(0, 7));
      if (!err && $urandom_range(0, 299) == 0) err = 1'b1;
      else if (err && $urandom_range(0, 15) == 0) err = 1'b0;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
